// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential divider among NREQ clients.
// One job at a time: grant, start pulse, wait for the divider or the watchdog, then report.
module divider_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 63,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WW     = (TIMEOUT < 3) ? 2 : $clog2(TIMEOUT + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DIVIDEND_IN,
  input  logic [NREQ*WIDTH-1:0] DIVISOR_IN,
  output logic [NREQ-1:0]       GNT,
  output logic                  BUSY,
  output logic                  DIV_START,
  output logic [WIDTH-1:0]      DIV_A,
  output logic [WIDTH-1:0]      DIV_B,
  input  logic                  DIV_FINISH,
  input  logic                  DIV_OV,
  input  logic                  DIV_DIVBYZERO,
  input  logic [WIDTH-1:0]      DIV_Q,
  input  logic [WIDTH-1:0]      DIV_R,
  output logic                  RES_VALID,
  output logic [IW-1:0]         RES_ID,
  output logic [WIDTH-1:0]      RES_Q,
  output logic [WIDTH-1:0]      RES_R,
  output logic [1:0]            RES_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rvalid_q, rvalid_d;
  logic [IW-1:0]    rid_q, rid_d;
  logic [WIDTH-1:0] rq_q, rq_d, rr_q, rr_d;
  logic [1:0]       err_q, err_d;
  logic [WW-1:0]    wdog_q, wdog_d;

  logic [WIDTH-1:0] dvd_arr [NREQ];
  logic [WIDTH-1:0] dvs_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign dvd_arr[gi] = DIVIDEND_IN[gi*WIDTH +: WIDTH];
      assign dvs_arr[gi] = DIVISOR_IN[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First requester at or after the pointer, scanning upward with wrap.
  logic          found;
  logic [IW-1:0] win_idx;
  always_comb begin
    logic [IW:0] sum;
    sum     = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && REQ[sum[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[IW-1:0];
      end
    end
  end

  // Error flags are meaningless while the divider is still loading operands.
  logic flags_live;
  assign flags_live = (wdog_q > WW'(1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    start_d  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    rvalid_d = 1'b0;
    rid_d    = rid_q;
    rq_d     = rq_q;
    rr_d     = rr_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_START;
          idx_d   = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          a_d     = dvd_arr[win_idx];
          b_d     = dvs_arr[win_idx];
          start_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wdog_d  = '0;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        if (DIV_FINISH || (flags_live && (DIV_DIVBYZERO || DIV_OV)) ||
            wdog_q == WW'(TIMEOUT)) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rid_d    = idx_q;
          rq_d     = '0;
          rr_d     = '0;
          if (DIV_FINISH) begin
            err_d = 2'b00;
            rq_d  = DIV_Q;
            rr_d  = DIV_R;
          end else if (flags_live && DIV_DIVBYZERO) begin
            err_d = 2'b10;
          end else if (flags_live && DIV_OV) begin
            err_d = 2'b01;
          end else begin
            err_d = 2'b11;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rq_q     <= '0;
      rr_q     <= '0;
      err_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rq_q     <= rq_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign GNT       = gnt_q;
  assign BUSY      = busy_q;
  assign DIV_START = start_q;
  assign DIV_A     = a_q;
  assign DIV_B     = b_q;
  assign RES_VALID = rvalid_q;
  assign RES_ID    = rid_q;
  assign RES_Q     = rq_q;
  assign RES_R     = rr_q;
  assign RES_ERR   = err_q;

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one sequential divider (start/finish handshake, OV and DIVBYZERO flags) among NREQ requesters using round-robin arbitration.
- Latches the winner's operands and drives a one-cycle start pulse to the divider.
- Waits for finish, error or watchdog timeout, then returns quotient/remainder with the requester ID and an error code.
- Sits between the client blocks and the divider's controller/datapath pair.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 10, operand/result width in bits.
- TIMEOUT, 63, watchdog limit in cycles spent in WAIT.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous active-low reset.
- REQ  input  NREQ  level request per requester.
- DIVIDEND_IN  input  NREQ*WIDTH  packed dividends; requester i at bits [i*WIDTH +: WIDTH].
- DIVISOR_IN  input  NREQ*WIDTH  packed divisors, same packing.
- GNT  output  NREQ  one-hot grant, held from grant until RES_VALID.
- BUSY  output  1  high in every state except IDLE.
- DIV_START  output  1  start pulse to the divider.
- DIV_A  output  WIDTH  latched dividend to the divider.
- DIV_B  output  WIDTH  latched divisor to the divider.
- DIV_FINISH  input  1  divider completion.
- DIV_OV  input  1  divider overflow flag.
- DIV_DIVBYZERO  input  1  divider divide-by-zero flag.
- DIV_Q  input  WIDTH  divider quotient.
- DIV_R  input  WIDTH  divider remainder.
- RES_VALID  output  1  one-cycle result strobe.
- RES_ID  output  $clog2(NREQ)  index of the requester being answered.
- RES_Q  output  WIDTH  captured quotient.
- RES_R  output  WIDTH  captured remainder.
- RES_ERR  output  2  00 ok, 01 overflow, 10 divide-by-zero, 11 timeout.

Behaviour:
- Reset (RST=0 at posedge): state=IDLE, PTR=0. GNT, BUSY, DIV_START, DIV_A, DIV_B, RES_VALID, RES_ID, RES_Q, RES_R, RES_ERR and the watchdog counter all go to 0. Reset overrides everything, including mid-operation. No result is issued for the aborted job. The divider's own reset is separate.
- All outputs are registered.
- IDLE:
  - If REQ != 0, grant the first requester at or after PTR in ascending order, wrapping.
  - Latch that requester's operands into DIV_A/DIV_B, set GNT one-hot, go to START.
  - If REQ == 0, stay in IDLE.
- START: DIV_START=1 for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT:
  - Watchdog counts up each cycle.
  - DIV_OV and DIV_DIVBYZERO are ignored for the first 2 WAIT cycles (the divider is still in init/load). They are sampled from the 3rd cycle onward.
  - Exit priority when several occur in the same cycle: DIV_FINISH (ERR=00) > DIV_DIVBYZERO (10) > DIV_OV (01) > watchdog==TIMEOUT (11).
  - On exit, capture DIV_Q/DIV_R (forced to 0 for any error) and go to RESP.
- RESP:
  - RES_VALID=1 for one cycle, with RES_ID = granted index.
  - Clear GNT, set PTR = granted+1 mod NREQ, go to IDLE.
  - RES_Q/RES_R/RES_ERR/RES_ID hold until the next RESP.
- Latency: REQ seen in IDLE at cycle t gives GNT at t+1 and DIV_START at t+1..t+2 (START state). RES_VALID comes 1 cycle after the divider's exit condition.
- Minimum idle gap: one IDLE cycle between jobs, so a REQ held continuously is re-arbitrated each job.
- REQ drop after grant: the operation still completes and the result is still delivered.
- Operand changes after grant: ignored.
- REQ arriving during BUSY: waits for the next IDLE.
- Fairness: a continuously requesting client is served at most NREQ jobs after its first request.
- NREQ=1: PTR stays 0.

Test Plan:
- Single request: REQ=0001, dividend 100, divisor 7; model divider finishes with Q=14 R=2 → GNT=0001, one DIV_START pulse, RES_VALID once with RES_ID=0, Q=14, R=2, ERR=00.
- Round-robin: REQ=1111 held for 4 jobs from PTR=0 → grants in order 0,1,2,3; REQ=1010 then gives order 1,3,1.
- Divide by zero: divisor 0; model raises DIVBYZERO in WAIT cycle 3 and never finishes → RES_ERR=10, Q=R=0. A spurious OV pulse in WAIT cycle 1 is ignored.
- Timeout: divider never responds → RES_VALID exactly TIMEOUT+1 cycles after entering WAIT with ERR=11; the next request is served normally.
- Simultaneous: FINISH and OV in the same cycle → ERR=00 with the captured Q/R.
- Reset mid-WAIT: RST=0 for one cycle → all outputs 0, no RES_VALID; next grant starts from requester 0.
